pll_lock_seq: RTL

Reset, lock-qualification and dynamic-reconfiguration sequencer for the board's rPLL (27 MHz reference in, divider-programmed system clock out). Runs entirely on the PLL reference clock. It holds the PLL in reset after power-up or on any divider change, drives the dynamic IDSEL/FBDSEL/ODSEL inputs, and waits for a debounced LOCK. Downstream logic receives a clock enable only while the PLL is qualified. It retries on lock timeout and reports a sticky fault after repeated failures.

---
 rtl/pll_lock_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: rPLL reset, lock qualification and dynamic divider sequencer.
// All logic runs on the 27 MHz PLL reference clock.
module pll_lock_seq #(
    parameter int         RST_CYCLES    = 32,
    parameter int         STABLE_CYCLES = 256,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         MAX_RETRY     = 3,
    parameter int         IDIV_DEF      = 6,
    parameter int         FBDIV_DEF     = 12,
    parameter logic [5:0] ODSEL_DEF     = 6'd0
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idiv,
    input  logic [5:0] cfg_fbdiv,
    input  logic [5:0] cfg_odsel,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel,
    output logic       clk_en,
    output logic       locked,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] relock_cnt
);

    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [5:0] ID_RST = 6'(63 - IDIV_DEF);
    localparam logic [5:0] FB_RST = 6'(63 - FBDIV_DEF);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RUN        = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic          r_meta;
    logic          r_lock_s;
    logic [HW-1:0] r_hold;
    logic [SW-1:0] r_stab;
    logic [TW-1:0] r_to;
    logic [RW-1:0] r_retry;

    logic          w_accept;
    logic          w_timeout;
    logic          w_hold_done;
    logic          w_stab_done;
    logic          w_to_exp;
    logic          w_wait_now;
    logic          w_wait_nxt;
    logic [RW-1:0] w_retry_inc;

    assign state       = r_state;
    assign w_accept    = cfg_valid & cfg_ready;
    assign w_hold_done = (r_hold == HW'(RST_CYCLES - 1));
    assign w_stab_done = (r_stab == SW'(STABLE_CYCLES - 1));
    assign w_to_exp    = (r_to == TW'(LOCK_TIMEOUT - 1));
    assign w_retry_inc = r_retry + 1'b1;
    assign w_wait_now  = (r_state == S_WAIT_LOCK) || (r_state == S_STABLE);
    assign w_wait_nxt  = (w_nxt == S_WAIT_LOCK) || (w_nxt == S_STABLE);

    // Qualifying on the final timeout cycle wins over the timeout itself.
    always_comb begin
        w_nxt     = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_RESET_HOLD: begin
                if (w_hold_done) w_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_to_exp)      w_timeout = 1'b1;
                else if (r_lock_s) w_nxt = S_STABLE;
            end
            S_STABLE: begin
                if (r_lock_s && w_stab_done) w_nxt = S_RUN;
                else if (w_to_exp)           w_timeout = 1'b1;
                else if (!r_lock_s)          w_nxt = S_WAIT_LOCK;
            end
            S_RUN: begin
                if (w_accept || !r_lock_s) w_nxt = S_RESET_HOLD;
            end
            S_FAULT: begin
                if (w_accept) w_nxt = S_RESET_HOLD;
            end
            default: w_nxt = S_RESET_HOLD;
        endcase
        if (w_timeout) begin
            w_nxt = (w_retry_inc == RW'(MAX_RETRY)) ? S_FAULT : S_RESET_HOLD;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state    <= S_RESET_HOLD;
            r_meta     <= 1'b0;
            r_lock_s   <= 1'b0;
            r_hold     <= '0;
            r_stab     <= '0;
            r_to       <= '0;
            r_retry    <= '0;
            relock_cnt <= '0;
            idsel      <= ID_RST;
            fbdsel     <= FB_RST;
            odsel      <= ODSEL_DEF;
            pll_reset  <= 1'b1;
            clk_en     <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            r_meta   <= pll_lock;
            r_lock_s <= r_meta;
            r_state  <= w_nxt;

            if (r_state == S_RESET_HOLD && w_nxt == S_RESET_HOLD)
                r_hold <= r_hold + 1'b1;
            else
                r_hold <= '0;

            if (r_state == S_STABLE && w_nxt == S_STABLE)
                r_stab <= r_stab + 1'b1;
            else
                r_stab <= '0;

            // Bounces between WAIT_LOCK and STABLE keep the timeout running.
            if (w_wait_now && w_wait_nxt)
                r_to <= r_to + 1'b1;
            else
                r_to <= '0;

            if (w_accept || (r_state == S_STABLE && w_nxt == S_RUN))
                r_retry <= '0;
            else if (w_timeout)
                r_retry <= w_retry_inc;

            if (r_state == S_RUN && !w_accept && !r_lock_s
                && relock_cnt != 8'd255)
                relock_cnt <= relock_cnt + 1'b1;

            if (w_accept) begin
                idsel  <= 6'd63 - cfg_idiv;
                fbdsel <= 6'd63 - cfg_fbdiv;
                odsel  <= cfg_odsel;
            end

            pll_reset <= (w_nxt == S_RESET_HOLD) || (w_nxt == S_FAULT);
            clk_en    <= (w_nxt == S_RUN);
            locked    <= (w_nxt == S_RUN);
            fault     <= (w_nxt == S_FAULT);
            cfg_ready <= (w_nxt == S_RUN) || (w_nxt == S_FAULT);
        end
    end

endmodule
